forward_dispatcher: RTL and testbench

FORWARD_DISPATCHER -- requirements
Module: forward_dispatcher

---
 rtl/forward_dispatcher.sv | 236 +++++++++++++++++++++++
 tb/tb_forward_dispatcher.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_dispatcher.sv
// Forward dispatcher: accepts one frame descriptor at a time, issues a MAC
// learn request for unicast sources, resolves the destination through an
// external lookup (or floods group destinations), then hands the frame
// pointer to every selected egress queue and waits for each queue to
// acknowledge before taking the next descriptor.
module forward_dispatcher #(
  parameter int NUM_PORTS   = 4,
  parameter int ADDR_W      = 10,
  parameter int LKP_TIMEOUT = 8,
  localparam int PW         = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frm_valid_i,
  output logic                          frm_ready_o,
  input  logic [ADDR_W-1:0]             frm_ptr_i,
  input  logic [47:0]                   frm_dst_i,
  input  logic [47:0]                   frm_src_i,
  input  logic [PW-1:0]                 frm_port_i,
  output logic                          lkp_req_o,
  output logic [47:0]                   lkp_mac_o,
  input  logic                          lkp_valid_i,
  input  logic                          lkp_hit_i,
  input  logic [PW-1:0]                 lkp_port_i,
  output logic                          lrn_en_o,
  output logic [47:0]                   lrn_mac_o,
  output logic [PW-1:0]                 lrn_port_o,
  output logic [NUM_PORTS-1:0]          wr_req_o,
  output logic [NUM_PORTS*ADDR_W-1:0]   wr_ptr_o,
  input  logic [NUM_PORTS-1:0]          wr_ack_i,
  output logic                          fanout_valid_o,
  output logic [PW:0]                   fanout_o,
  output logic                          drop_o,
  output logic                          tmo_o
);

  // Lookup wait counter only needs to reach LKP_TIMEOUT-1.
  localparam int CW = (LKP_TIMEOUT > 1) ? $clog2(LKP_TIMEOUT) : 1;
  localparam logic [CW-1:0]        TMO_LAST  = CW'(LKP_TIMEOUT - 1);
  localparam logic [NUM_PORTS-1:0] ALL_PORTS = {NUM_PORTS{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOOKUP   = 2'd1,
    ST_DISPATCH = 2'd2
  } state_t;

  state_t                        state_r;
  logic                          ready_r;
  logic [ADDR_W-1:0]             ptr_r;
  logic [47:0]                   dst_r;
  logic [47:0]                   src_r;
  logic [PW-1:0]                 port_r;
  logic                          lkp_req_r;
  logic                          lrn_en_r;
  logic [NUM_PORTS-1:0]          pend_r;
  logic [NUM_PORTS*ADDR_W-1:0]   wr_ptr_r;
  logic                          fanout_valid_r;
  logic [PW:0]                   fanout_r;
  logic                          drop_r;
  logic                          tmo_r;
  logic [CW-1:0]                 wait_r;

  logic                          accept_s;
  logic [NUM_PORTS-1:0]          grp_mask_s;
  logic [NUM_PORTS-1:0]          flood_mask_s;
  logic [NUM_PORTS-1:0]          lkp_bit_s;
  logic                          lkp_in_range_s;
  logic                          lkp_self_s;
  logic [NUM_PORTS-1:0]          uni_mask_s;
  logic [NUM_PORTS-1:0]          ack_mask_s;
  logic                          tmo_hit_s;

  // One-hot port select; an out-of-range port number yields an empty mask.
  function automatic logic [NUM_PORTS-1:0] port_bit(input logic [PW-1:0] p);
    logic [NUM_PORTS-1:0] m;
    m = {NUM_PORTS{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      m[i] = (p == PW'(i));
    end
    return m;
  endfunction

  // Number of set bits in a port mask (destination count for refcount).
  function automatic logic [PW:0] popcount(input logic [NUM_PORTS-1:0] m);
    logic [PW:0] c;
    c = {(PW+1){1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      c = c + {{PW{1'b0}}, m[i]};
    end
    return c;
  endfunction

  // Replicate the frame pointer onto every selected port lane, zero elsewhere.
  function automatic logic [NUM_PORTS*ADDR_W-1:0] ptr_fill(
    input logic [NUM_PORTS-1:0] m,
    input logic [ADDR_W-1:0]    ptr
  );
    logic [NUM_PORTS*ADDR_W-1:0] v;
    v = {(NUM_PORTS*ADDR_W){1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      v[i*ADDR_W +: ADDR_W] = m[i] ? ptr : {ADDR_W{1'b0}};
    end
    return v;
  endfunction

  // Forwarding decisions derived from the current inputs and latched frame.
  always_comb begin
    accept_s       = frm_valid_i & ready_r & (state_r == ST_IDLE);
    grp_mask_s     = ALL_PORTS & ~port_bit(frm_port_i);
    flood_mask_s   = ALL_PORTS & ~port_bit(port_r);
    lkp_bit_s      = port_bit(lkp_port_i);
    lkp_in_range_s = |lkp_bit_s;
    lkp_self_s     = lkp_hit_i & lkp_in_range_s & (lkp_port_i == port_r);
    if (lkp_hit_i && lkp_in_range_s) begin
      uni_mask_s = lkp_bit_s;
    end else begin
      uni_mask_s = flood_mask_s;
    end
    ack_mask_s = pend_r & ~wr_ack_i;
    tmo_hit_s  = (wait_r == TMO_LAST);
  end

  // Control FSM with all outputs registered; pulses default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      ready_r        <= 1'b0;
      ptr_r          <= {ADDR_W{1'b0}};
      dst_r          <= 48'd0;
      src_r          <= 48'd0;
      port_r         <= {PW{1'b0}};
      lkp_req_r      <= 1'b0;
      lrn_en_r       <= 1'b0;
      pend_r         <= {NUM_PORTS{1'b0}};
      wr_ptr_r       <= {(NUM_PORTS*ADDR_W){1'b0}};
      fanout_valid_r <= 1'b0;
      fanout_r       <= {(PW+1){1'b0}};
      drop_r         <= 1'b0;
      tmo_r          <= 1'b0;
      wait_r         <= {CW{1'b0}};
    end else begin
      lkp_req_r      <= 1'b0;
      lrn_en_r       <= 1'b0;
      fanout_valid_r <= 1'b0;
      drop_r         <= 1'b0;
      tmo_r          <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            ptr_r    <= frm_ptr_i;
            dst_r    <= frm_dst_i;
            src_r    <= frm_src_i;
            port_r   <= frm_port_i;
            ready_r  <= 1'b0;
            wait_r   <= {CW{1'b0}};
            // Group source addresses are never learned.
            lrn_en_r <= ~frm_src_i[40];
            if (frm_dst_i[40]) begin
              state_r        <= ST_DISPATCH;
              pend_r         <= grp_mask_s;
              wr_ptr_r       <= ptr_fill(grp_mask_s, frm_ptr_i);
              fanout_valid_r <= 1'b1;
              fanout_r       <= popcount(grp_mask_s);
            end else begin
              state_r   <= ST_LOOKUP;
              lkp_req_r <= 1'b1;
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_LOOKUP: begin
          if (lkp_valid_i) begin
            wait_r <= {CW{1'b0}};
            if (lkp_self_s) begin
              // Destination sits behind the ingress port: nothing to send.
              state_r        <= ST_IDLE;
              ready_r        <= 1'b1;
              drop_r         <= 1'b1;
              fanout_valid_r <= 1'b1;
              fanout_r       <= {(PW+1){1'b0}};
            end else begin
              state_r        <= ST_DISPATCH;
              pend_r         <= uni_mask_s;
              wr_ptr_r       <= ptr_fill(uni_mask_s, ptr_r);
              fanout_valid_r <= 1'b1;
              fanout_r       <= popcount(uni_mask_s);
            end
          end else if (tmo_hit_s) begin
            wait_r         <= {CW{1'b0}};
            tmo_r          <= 1'b1;
            state_r        <= ST_DISPATCH;
            pend_r         <= flood_mask_s;
            wr_ptr_r       <= ptr_fill(flood_mask_s, ptr_r);
            fanout_valid_r <= 1'b1;
            fanout_r       <= popcount(flood_mask_s);
          end else begin
            wait_r <= wait_r + CW'(1);
          end
        end
        ST_DISPATCH: begin
          if (pend_r == {NUM_PORTS{1'b0}}) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
          end else begin
            // Acks only clear lanes that are still requesting.
            pend_r   <= ack_mask_s;
            wr_ptr_r <= ptr_fill(ack_mask_s, ptr_r);
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          ready_r  <= 1'b0;
          pend_r   <= {NUM_PORTS{1'b0}};
          wr_ptr_r <= {(NUM_PORTS*ADDR_W){1'b0}};
          wait_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign frm_ready_o    = ready_r;
  assign lkp_req_o      = lkp_req_r;
  assign lkp_mac_o      = dst_r;
  assign lrn_en_o       = lrn_en_r;
  assign lrn_mac_o      = src_r;
  assign lrn_port_o     = port_r;
  assign wr_req_o       = pend_r;
  assign wr_ptr_o       = wr_ptr_r;
  assign fanout_valid_o = fanout_valid_r;
  assign fanout_o       = fanout_r;
  assign drop_o         = drop_r;
  assign tmo_o          = tmo_r;

endmodule

// File: tb/tb_forward_dispatcher.sv
// Bench for forward_dispatcher: directed scenarios plus randomized frames,
// each checked against a forwarding-rule model held in the bench.
module tb_forward_dispatcher;

  localparam int NP  = 4;
  localparam int AW  = 10;
  localparam int TMO = 8;
  localparam int PW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frm_valid_i = 1'b0;
  logic              frm_ready_o;
  logic [AW-1:0]     frm_ptr_i = '0;
  logic [47:0]       frm_dst_i = '0;
  logic [47:0]       frm_src_i = '0;
  logic [PW-1:0]     frm_port_i = '0;
  logic              lkp_req_o;
  logic [47:0]       lkp_mac_o;
  logic              lkp_valid_i = 1'b0;
  logic              lkp_hit_i = 1'b0;
  logic [PW-1:0]     lkp_port_i = '0;
  logic              lrn_en_o;
  logic [47:0]       lrn_mac_o;
  logic [PW-1:0]     lrn_port_o;
  logic [NP-1:0]     wr_req_o;
  logic [NP*AW-1:0]  wr_ptr_o;
  logic [NP-1:0]     wr_ack_i = '0;
  logic              fanout_valid_o;
  logic [PW:0]       fanout_o;
  logic              drop_o;
  logic              tmo_o;

  int checks = 0;
  int fails  = 0;
  logic [NP-1:0] ack_q[$];

  always #5 clk = ~clk;

  forward_dispatcher #(.NUM_PORTS(NP), .ADDR_W(AW), .LKP_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .frm_valid_i(frm_valid_i), .frm_ready_o(frm_ready_o), .frm_ptr_i(frm_ptr_i),
    .frm_dst_i(frm_dst_i), .frm_src_i(frm_src_i), .frm_port_i(frm_port_i),
    .lkp_req_o(lkp_req_o), .lkp_mac_o(lkp_mac_o),
    .lkp_valid_i(lkp_valid_i), .lkp_hit_i(lkp_hit_i), .lkp_port_i(lkp_port_i),
    .lrn_en_o(lrn_en_o), .lrn_mac_o(lrn_mac_o), .lrn_port_o(lrn_port_o),
    .wr_req_o(wr_req_o), .wr_ptr_o(wr_ptr_o), .wr_ack_i(wr_ack_i),
    .fanout_valid_o(fanout_valid_o), .fanout_o(fanout_o),
    .drop_o(drop_o), .tmo_o(tmo_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({frm_ready_o, lkp_req_o, lrn_en_o, fanout_valid_o, drop_o, tmo_o} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b required 000000",
        {frm_ready_o, lkp_req_o, lrn_en_o, fanout_valid_o, drop_o, tmo_o});
    end
    checks++;
    if ({wr_req_o, wr_ptr_o, fanout_o, lkp_mac_o, lrn_mac_o, lrn_port_o} !== '0) begin
      fails++; $display("FAIL reset_data: wr_req=%b wr_ptr=%h fanout=%0d required all zero",
        wr_req_o, wr_ptr_o, fanout_o);
    end
    rst_n = 1'b1;
    checks++;
    if (frm_ready_o !== 1'b0) begin
      fails++; $display("FAIL reset_release_ready: got %b required 0", frm_ready_o);
    end
    tick();
    checks++;
    if (frm_ready_o !== 1'b1) begin
      fails++; $display("FAIL ready_after_reset: got %b required 1", frm_ready_o);
    end
  endtask

  // Drives acks until the model's pending mask empties, then checks the return to idle.
  task automatic run_acks(input logic [NP-1:0] mask, input logic [AW-1:0] ptr);
    logic [NP-1:0]    pend;
    logic [NP-1:0]    ack;
    logic [NP*AW-1:0] exp_ptr;
    int n;
    pend = mask;
    n = 0;
    while (pend != '0 && n < 200) begin
      exp_ptr = '0;
      for (int p = 0; p < NP; p++) if (pend[p]) exp_ptr[p*AW +: AW] = ptr;
      checks++;
      if (wr_req_o !== pend) begin
        fails++; $display("FAIL wr_req: got %b required %b", wr_req_o, pend);
      end
      checks++;
      if (wr_ptr_o !== exp_ptr) begin
        fails++; $display("FAIL wr_ptr: got %h required %h", wr_ptr_o, exp_ptr);
      end
      if (n > 0) begin
        checks++;
        if ({fanout_valid_o, lrn_en_o, tmo_o, drop_o} !== 4'b0) begin
          fails++; $display("FAIL pulse_stuck: got %b required 0000",
            {fanout_valid_o, lrn_en_o, tmo_o, drop_o});
        end
      end
      if (ack_q.size() > 0) ack = ack_q.pop_front();
      else ack = NP'($urandom_range(0, (1 << NP) - 1));
      wr_ack_i = ack;
      tick();
      pend = pend & ~ack;
      n++;
    end
    wr_ack_i = '0;
    checks++;
    if (pend != '0) begin
      fails++; $display("FAIL ack_bound: pending %b left after %0d cycles", pend, n);
    end
    checks++;
    if ({wr_req_o, frm_ready_o} !== {{NP{1'b0}}, 1'b0}) begin
      fails++; $display("FAIL drain_cycle: wr_req=%b ready=%b required 0000/0", wr_req_o, frm_ready_o);
    end
    tick();
    checks++;
    if (frm_ready_o !== 1'b1) begin
      fails++; $display("FAIL ready_return: got %b required 1", frm_ready_o);
    end
  endtask

  // One complete frame; delay = lookup cycles waited after the request cycle
  // before the response (delay >= TMO means the lookup never answers).
  task automatic run_frame(input logic [47:0] dst, input logic [47:0] src, input int ing,
                           input logic [AW-1:0] ptr, input int delay, input logic hit,
                           input int lport, input bit late);
    logic [NP-1:0] flood, mask;
    bit exp_drop, exp_tmo, learn;
    int n;
    flood    = ~(NP'(1) << ing);
    learn    = !src[40];
    exp_drop = 1'b0;
    exp_tmo  = 1'b0;
    if (dst[40])               mask = flood;
    else if (delay >= TMO)     begin mask = flood; exp_tmo = 1'b1; end
    else if (hit && lport == ing) begin mask = '0; exp_drop = 1'b1; end
    else if (hit)              mask = NP'(1) << lport;
    else                       mask = flood;

    n = 0;
    while (frm_ready_o !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (frm_ready_o !== 1'b1) begin
      fails++; $display("FAIL ready_wait: got %b required 1", frm_ready_o);
    end
    frm_valid_i = 1'b1; frm_dst_i = dst; frm_src_i = src;
    frm_port_i = PW'(ing); frm_ptr_i = ptr;
    tick();
    frm_valid_i = 1'b0;
    checks++;
    if ({lrn_en_o, frm_ready_o} !== {learn, 1'b0}) begin
      fails++; $display("FAIL accept: lrn_en/ready got %b required %b", {lrn_en_o, frm_ready_o}, {learn, 1'b0});
    end
    if (learn) begin
      checks++;
      if ({lrn_mac_o, lrn_port_o} !== {src, PW'(ing)}) begin
        fails++; $display("FAIL learn_key: got %h/%0d required %h/%0d", lrn_mac_o, lrn_port_o, src, ing);
      end
    end
    if (dst[40]) begin
      checks++;
      if (lkp_req_o !== 1'b0) begin
        fails++; $display("FAIL group_no_lookup: lkp_req got %b required 0", lkp_req_o);
      end
    end else begin
      for (int k = 1; k <= TMO; k++) begin
        checks++;
        if ({lkp_req_o, wr_req_o, tmo_o} !== {(k == 1), {NP{1'b0}}, 1'b0}) begin
          fails++; $display("FAIL lookup_cycle%0d: req/wr_req/tmo got %b required %b", k,
            {lkp_req_o, wr_req_o, tmo_o}, {(k == 1), {NP{1'b0}}, 1'b0});
        end
        checks++;
        if (lkp_mac_o !== dst) begin
          fails++; $display("FAIL lookup_key: got %h required %h", lkp_mac_o, dst);
        end
        if (k > 1) begin
          checks++;
          if (lrn_en_o !== 1'b0) begin
            fails++; $display("FAIL learn_pulse_width: got %b required 0", lrn_en_o);
          end
        end
        if (k == delay + 1) begin
          lkp_valid_i = 1'b1; lkp_hit_i = hit; lkp_port_i = PW'(lport);
          tick();
          lkp_valid_i = 1'b0;
          break;
        end
        tick();
      end
    end
    checks++;
    if ({drop_o, tmo_o, fanout_valid_o} !== {exp_drop, exp_tmo, 1'b1}) begin
      fails++; $display("FAIL decision: drop/tmo/fanout_valid got %b required %b",
        {drop_o, tmo_o, fanout_valid_o}, {exp_drop, exp_tmo, 1'b1});
    end
    checks++;
    if ({fanout_o, wr_req_o} !== {3'($countones(mask)), mask}) begin
      fails++; $display("FAIL dispatch_entry: fanout=%0d wr_req=%b required %0d/%b",
        fanout_o, wr_req_o, $countones(mask), mask);
    end
    if (exp_drop) begin
      checks++;
      if (frm_ready_o !== 1'b1) begin
        fails++; $display("FAIL drop_ready: got %b required 1", frm_ready_o);
      end
      tick();
      checks++;
      if ({drop_o, fanout_valid_o, wr_req_o} !== '0) begin
        fails++; $display("FAIL drop_after: drop/fv/wr_req got %b required 0",
          {drop_o, fanout_valid_o, wr_req_o});
      end
    end else begin
      if (late) begin
        lkp_valid_i = 1'b1; lkp_hit_i = 1'b1; lkp_port_i = PW'((ing + 1) % NP);
        tick();
        lkp_valid_i = 1'b0;
        checks++;
        if ({wr_req_o, fanout_valid_o, tmo_o} !== {mask, 2'b00}) begin
          fails++; $display("FAIL late_lookup: wr_req/fv/tmo got %b required %b",
            {wr_req_o, fanout_valid_o, tmo_o}, {mask, 2'b00});
        end
      end
      run_acks(mask, ptr);
    end
  endtask

  task automatic test_unicast_hit;
    run_frame({8'h02, 40'h00_1122_3344}, {8'h02, 40'h00_AABB_CCDD}, 1, 10'h155, 2, 1'b1, 3, 1'b0);
  endtask

  task automatic test_broadcast;
    ack_q = {4'b0100, 4'b1001, 4'b0100, 4'b0010};
    run_frame(48'hFFFF_FFFF_FFFF, {8'h04, 40'h00_0000_0042}, 2, 10'h2A3, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_drop;
    run_frame({8'h0A, 40'h00_1234_5678}, {8'h0A, 40'h00_8765_4321}, 2, 10'h0F0,
              int'($urandom_range(0, TMO - 1)), 1'b1, 2, 1'b0);
  endtask

  task automatic test_timeout;
    run_frame({8'h06, 40'h00_0BAD_F00D}, {8'h01, 40'h00_0000_0001}, 0, 10'h3FF, TMO, 1'b1, 1, 1'b1);
  endtask

  task automatic test_reset_mid_frame;
    int n;
    n = 0;
    while (frm_ready_o !== 1'b1 && n < 50) begin tick(); n++; end
    frm_valid_i = 1'b1; frm_dst_i = 48'hFFFF_FFFF_FFFF; frm_src_i = 48'h0200_0000_0077;
    frm_port_i = 2'd2; frm_ptr_i = 10'h111;
    tick();
    frm_valid_i = 1'b0;
    wr_ack_i = 4'b0001;
    tick();
    wr_ack_i = 4'b0000;
    checks++;
    if (wr_req_o !== 4'b1010) begin
      fails++; $display("FAIL mid_frame_pending: got %b required 1010", wr_req_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_req_o, wr_ptr_o, frm_ready_o, lkp_req_o, lrn_en_o, fanout_valid_o, fanout_o, drop_o, tmo_o} !== '0) begin
      fails++; $display("FAIL async_reset: wr_req=%b wr_ptr=%h ready=%b fv=%b required all zero",
        wr_req_o, wr_ptr_o, frm_ready_o, fanout_valid_o);
    end
    tick();
    checks++;
    if ({wr_req_o, frm_ready_o, fanout_valid_o, drop_o, tmo_o, lrn_en_o} !== '0) begin
      fails++; $display("FAIL reset_hold: got %b required all zero",
        {wr_req_o, frm_ready_o, fanout_valid_o, drop_o, tmo_o, lrn_en_o});
    end
    rst_n = 1'b1;
    run_frame({8'h02, 40'h00_5555_0000}, {8'h02, 40'h00_6666_0000}, 3, 10'h321, 1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_random;
    logic [47:0] dst, src;
    for (int i = 0; i < 30; i++) begin
      dst = {16'($urandom), $urandom};
      src = {16'($urandom), $urandom};
      dst[40] = ($urandom_range(0, 3) == 0);
      src[40] = ($urandom_range(0, 3) == 0);
      run_frame(dst, src, int'($urandom_range(0, NP - 1)), AW'($urandom),
                int'($urandom_range(0, TMO + 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, NP - 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_unicast_hit();
    test_broadcast();
    test_drop();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
